// File: rtl/float_sort_pkg.sv
// Shared types and widths for the sequential float sorter.
package float_sort_pkg;

    localparam int FLOAT_W = 32;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } sort_state_t;

endpackage

// File: rtl/float_greater_than.sv
// Combinational IEEE-754 single-precision "float1 > float2" by bit fields.
module float_greater_than
    import float_sort_pkg::*;
(
    input  logic [FLOAT_W-1:0] float1,
    input  logic [FLOAT_W-1:0] float2,
    output logic               gt
);

    logic       sign1, sign2;
    logic [7:0] exp1, exp2;
    logic [22:0] mant1, mant2;
    logic       mag_gt, mag_lt;

    assign sign1 = float1[31];
    assign sign2 = float2[31];
    assign exp1  = float1[30:23];
    assign exp2  = float2[30:23];
    assign mant1 = float1[22:0];
    assign mant2 = float2[22:0];

    always_comb begin
        mag_gt = (exp1 > exp2) || ((exp1 == exp2) && (mant1 > mant2));
        mag_lt = (exp1 < exp2) || ((exp1 == exp2) && (mant1 < mant2));
        if (sign1 != sign2) begin
            // Any positive beats any negative, so +0 > -0.
            gt = sign2;
        end else if (sign1) begin
            gt = mag_lt;
        end else begin
            gt = mag_gt;
        end
    end

endmodule

// File: rtl/float_sort_seq.sv
// Block sorter: load N floats, bubble-sort in place with one shared comparator, drain ascending.
module float_sort_seq
    import float_sort_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N - 2);

    sort_state_t        state, state_nxt;
    logic [31:0]        mem [N];
    logic [IDX_W-1:0]   cnt;
    logic [IDX_W-1:0]   pass;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_inc;
    logic               swapped;
    logic [31:0]        op_a, op_b;
    logic               gt;
    logic               swap;
    logic               idx_last;

    assign idx_inc  = idx + 1'b1;
    assign op_a     = mem[idx];
    assign op_b     = mem[idx_inc];
    // The last compare of pass p sits at N-2-p: each pass parks the largest remaining word.
    assign idx_last = (idx == (IDX_TOP - pass));

    float_greater_than u_cmp (
        .float1 (op_a),
        .float2 (op_b),
        .gt     (gt)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        // Bitwise-equal guard keeps equal words in place, so a pass of equals counts as clean.
        swap      = (state == SORT) && gt && (op_a != op_b);
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == CNT_LAST)) begin
                    state_nxt = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (idx_last && (!(swapped || swap) || (pass == IDX_TOP))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = mem[cnt];
                if (out_ready && (cnt == CNT_LAST)) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOAD;
            cnt     <= '0;
            pass    <= '0;
            idx     <= '0;
            swapped <= 1'b0;
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        mem[cnt] <= in_data;
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            idx     <= '0;
                            pass    <= '0;
                            swapped <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                SORT: begin
                    if (swap) begin
                        mem[idx]     <= op_b;
                        mem[idx_inc] <= op_a;
                        swapped      <= 1'b1;
                    end
                    if (idx_last) begin
                        if (state_nxt == DRAIN) begin
                            cnt <= '0;
                        end else begin
                            pass    <= pass + 1'b1;
                            idx     <= '0;
                            swapped <= 1'b0;
                        end
                    end else begin
                        idx <= idx_inc;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
